uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
// - Serial-to-parallel UART receiver. It is the far end of the existing transmitter: 8N1 framing, LSB first, line idle high.
// - Samples serial_connection at OVERSAMPLE x baud using an internal tick enable. All logic runs on the 100 MHz system clock; there is no divided clock.
// - Delivers each byte through a valid/ready handshake. Flags framing errors and overruns.
// PARAMETERS
// - CLOCK_HZ    100_000_000  system clock frequency
// - BAUD        115_200      line rate
// - OVERSAMPLE  16           ticks per bit; must be even and >= 8
// - Derived: DIVISOR = CLOCK_HZ/(BAUD*OVERSAMPLE), truncated = 54. One bit time = 864 clocks.
// PORTS
// - clock            in   1  system clock; all logic on posedge
// - reset            in   1  synchronous, active-high
// - serial_connection in  1  asynchronous RX line, idle high
// - data             out  8  received byte; stable while valid=1
// - valid            out  1  data holds an unconsumed byte
// - ready            in   1  consumer accepts; transfer happens when valid&ready
// - framing_error    out  1  1-cycle pulse: stop bit sampled low
// - overrun          out  1  1-cycle pulse: byte completed while valid&!ready
// - busy             out  1  state != IDLE
// BEHAVIOUR
// - Reset values: data=0, valid=0, framing_error=0, overrun=0, busy=0, state=IDLE, all counters=0.
// - Sync: 2-FF synchronizer on serial_connection. Both flops reset to 1. The edge-detect previous-sample register resets to 0, so a line held low through reset never starts a frame; a high level must be seen first.
// - Tick: counter 0..DIVISOR-1. Emits tick for 1 cycle at DIVISOR-1. The counter is cleared on the falling-edge detection in IDLE, which aligns phase to the start edge.
// - sample_cnt counts ticks 0..OVERSAMPLE-1 within each bit.
// - Bit value = majority of synced samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
// - FSM: IDLE -> START on synced falling edge.
// - START: at tick OVERSAMPLE/2+1, vote==0 -> DATA; vote==1 -> IDLE (glitch, nothing reported).
// - START continued: the bit boundary then runs OVERSAMPLE ticks from the edge.
// - DATA: each bit end, shift the voted bit in at MSB and shift right (LSB first). After bit_idx==7 -> STOP.
// - STOP: at the vote point:
//   - vote==1 -> deliver byte, go IDLE at once (next start edge can be seen in the second half of the stop bit).
//   - vote==0 -> framing_error=1 for 1 cycle, byte discarded, -> IDLE.
// - Deliver, valid==0: data<=byte, valid<=1 on the next clock.
// - Deliver, valid&ready in the same cycle: new byte loaded, valid stays 1, no overrun.
// - Deliver, valid&!ready: old data kept, new byte dropped, overrun=1 for 1 cycle.
// - valid&ready with no delivery -> valid<=0 next cycle. data holds its last value.
// - Latency: valid rises 1 clock after the stop-bit centre vote, ~2 sync + 9.5 bit times after the line edge.
// - Reset mid-frame: immediate IDLE, shift register and partial byte discarded, no flags.
// - Baud error tolerance: frames with <=3% rate mismatch must decode.
// STRUCTURE
// - uart_pkg holds:
//   - state encoding IDLE=0, START=1, DATA=2, STOP=3 (2 bits)
//   - DATA_BITS=8
//   - a divisor constant function shared with the transmitter.
// - One sub-module: baud_tick_generator (params CLOCK_HZ, BAUD, OVERSAMPLE; ports clock, reset, clear, tick). It is also reusable by the transmitter with OVERSAMPLE=1.
// - Synchronizer, voter, FSM, shift register and output handshake stay inline.
// TESTING
// - Bench drives the line from a behavioural 115200 8N1 driver. The existing transmitter is used as a loopback source in the last case.
// 1. Idle high, send 0xAB, ready=1 -> valid 1 cycle, data=0xAB, no flags, busy falls after the stop centre.
// 2. Back-to-back 0x00,0xFF,0x55, 1 stop bit each, ready=1 -> three valids in order, data values exact.
// 3. Line low 3 ticks (162 clocks) then high -> no valid, no flags, FSM back in IDLE before the next bit time.
// 4. Send 0x55 with stop bit forced low -> framing_error pulses once, valid stays 0; a following 0x3C decodes cleanly.
// 5. ready=0, send 0x12 then 0x34 -> data=0x12, valid=1, one overrun pulse. Then ready=1 for 1 cycle -> valid falls.
// 6. reset during bit 4 of 0xA5 with line held low through reset -> no spurious frame. Then send 0xC3 -> data=0xC3.
// 7. Loopback: transmitter sends 0xAB -> data=0xAB at valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and the baud divisor
// helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Clocks per tick, truncated; 100 MHz / (115200 * 16) = 54.
  function automatic int baud_divisor(input int clock_hz, input int baud, input int oversample);
    return clock_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_baud_tick.sv
// Free-running tick enable at BAUD*OVERSAMPLE; clear restarts the phase so the
// first tick lands a full divisor period later.
module baud_tick_generator
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIVISOR = baud_divisor(CLOCK_HZ, BAUD, OVERSAMPLE);
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CNT_W-1:0] count_reg;

  assign tick = (count_reg == CNT_W'(DIVISOR - 1));

  always_ff @(posedge clock) begin
    if (reset || clear || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: oversampled start-edge alignment, 3-sample majority vote
// per bit, valid/ready output with framing-error and overrun pulses.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_connection,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] VOTE_LO  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] VOTE_MID = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] VOTE_HI  = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0] BIT_END  = SC_W'(OVERSAMPLE - 1);

  logic                 sync1_reg, sync2_reg, prev_reg;
  logic [1:0]           flush_reg;
  uart_state_e          state_reg;
  logic [SC_W-1:0]      sample_cnt_reg;
  logic [2:0]           bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 s0_reg, s1_reg;
  logic                 tick, start_edge, vote;

  assign start_edge = (state_reg == IDLE) && prev_reg && !sync2_reg;
  assign vote       = (s0_reg & s1_reg) | (s0_reg & sync2_reg) | (s1_reg & sync2_reg);
  assign busy       = (state_reg != IDLE);

  baud_tick_generator #(
    .CLOCK_HZ  (CLOCK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(start_edge),
    .tick (tick)
  );

  // prev_reg ignores the synchronizer's reset contents, so only a genuinely
  // observed high level can arm start detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b0;
      flush_reg <= 2'b00;
    end else begin
      sync1_reg <= serial_connection;
      sync2_reg <= sync1_reg;
      flush_reg <= {flush_reg[0], 1'b1};
      prev_reg  <= flush_reg[1] ? sync2_reg : 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      sample_cnt_reg <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      s0_reg         <= 1'b0;
      s1_reg         <= 1'b0;
      data           <= '0;
      valid          <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      if (state_reg == IDLE) begin
        if (start_edge) begin
          state_reg      <= START;
          sample_cnt_reg <= '0;
          bit_idx_reg    <= '0;
        end
      end else if (tick) begin
        sample_cnt_reg <= (sample_cnt_reg == BIT_END) ? '0 : sample_cnt_reg + 1'b1;
        if (sample_cnt_reg == VOTE_LO)  s0_reg <= sync2_reg;
        if (sample_cnt_reg == VOTE_MID) s1_reg <= sync2_reg;

        case (state_reg)
          START: begin
            if (sample_cnt_reg == VOTE_HI && vote) state_reg <= IDLE;
            else if (sample_cnt_reg == BIT_END)    state_reg <= DATA;
          end
          DATA: begin
            if (sample_cnt_reg == VOTE_HI) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
            if (sample_cnt_reg == BIT_END) begin
              if (bit_idx_reg == 3'(DATA_BITS - 1)) state_reg <= STOP;
              else bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
          STOP: begin
            // Return to IDLE at the stop centre so a back-to-back start edge is caught.
            if (sample_cnt_reg == VOTE_HI) begin
              state_reg <= IDLE;
              if (!vote) begin
                framing_error <= 1'b1;
              end else if (!valid || ready) begin
                data  <= shift_reg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: behavioural 8N1 line driver plus a
// small tick-driven transmitter for the loopback case.
module tb_uart_rx_oversampled;

  // 625 kbaud divides 100 MHz exactly for both the x16 and the x1 divider.
  localparam int CLK_HZ  = 100_000_000;
  localparam int TB_BAUD = 625_000;
  localparam int TICK    = CLK_HZ / (TB_BAUD * 16);
  localparam int BIT     = TICK * 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       serial_connection;
  logic [7:0] data;
  logic       valid, ready, framing_error, overrun, busy;

  logic       drv_line;
  logic       use_tx;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cycles = 0;
  logic [7:0] rx_q[$];

  always #5 clock = ~clock;

  uart_rx_oversampled #(
    .CLOCK_HZ(CLK_HZ), .BAUD(TB_BAUD), .OVERSAMPLE(16)
  ) dut (
    .clock(clock), .reset(reset), .serial_connection(serial_connection),
    .data(data), .valid(valid), .ready(ready),
    .framing_error(framing_error), .overrun(overrun), .busy(busy)
  );

  // Loopback transmitter built on the shared tick generator.
  logic       tx_go, tx_line, tx_active, tx_tick, tx_load;
  logic [7:0] tx_byte;
  logic [8:0] tx_frame;
  int         tx_left;

  assign tx_load = tx_go && !tx_active;

  baud_tick_generator #(
    .CLOCK_HZ(CLK_HZ), .BAUD(TB_BAUD), .OVERSAMPLE(1)
  ) u_tx_tick (
    .clock(clock), .reset(reset), .clear(tx_load), .tick(tx_tick)
  );

  always @(posedge clock) begin
    if (reset) begin
      tx_line   <= 1'b1;
      tx_active <= 1'b0;
      tx_left   <= 0;
      tx_frame  <= '1;
    end else if (tx_load) begin
      tx_line   <= 1'b0;
      tx_frame  <= {1'b1, tx_byte};
      tx_left   <= 9;
      tx_active <= 1'b1;
    end else if (tx_active && tx_tick) begin
      if (tx_left > 0) begin
        tx_line  <= tx_frame[0];
        tx_frame <= {1'b1, tx_frame[8:1]};
        tx_left  <= tx_left - 1;
      end else begin
        tx_active <= 1'b0;
      end
    end
  end

  assign serial_connection = use_tx ? tx_line : drv_line;

  always @(negedge clock) begin
    if (!reset) begin
      if (valid) valid_cycles++;
      if (valid && ready) begin
        rx_q.push_back(data);
        $display("rx byte 0x%02h at %0t", data, $time);
      end
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drv_line = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      drv_line = b[i];
      wait_clks(BIT);
    end
    drv_line = stop_bit;
    wait_clks(BIT);
    drv_line = 1'b1;
    $display("sent byte 0x%02h stop=%0b", b, stop_bit);
  endtask

  task automatic clear_counts();
    rx_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    valid_cycles = 0;
  endtask

  initial begin
    reset    = 1'b1;
    drv_line = 1'b1;
    use_tx   = 1'b0;
    ready    = 1'b1;
    tx_go    = 1'b0;
    tx_byte  = 8'h00;
    wait_clks(5);
    reset = 1'b0;
    wait_clks(1);
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_flags", {framing_error, overrun}, 2'b00);
    check("reset_busy", busy, 1'b0);
    wait_clks(50);

    // 1: single byte
    clear_counts();
    send_byte(8'hAB, 1'b1);
    wait_clks(20);
    check("t1_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t1_data", rx_q[0], 8'hAB);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_flags", fe_cnt + ov_cnt, 0);
    check("t1_busy", busy, 1'b0);

    // 2: back-to-back frames, one stop bit each
    clear_counts();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_clks(20);
    check("t2_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("t2_data0", rx_q[0], 8'h00);
      check("t2_data1", rx_q[1], 8'hFF);
      check("t2_data2", rx_q[2], 8'h55);
    end
    check("t2_flags", fe_cnt + ov_cnt, 0);

    // 3: 3-tick glitch
    clear_counts();
    drv_line = 1'b0;
    wait_clks(3 * TICK);
    drv_line = 1'b1;
    wait_clks(140 - 3 * TICK);
    check("t3_idle_in_bit", busy, 1'b0);
    wait_clks(2 * BIT);
    check("t3_count", rx_q.size(), 0);
    check("t3_flags", fe_cnt + ov_cnt, 0);

    // 4: framing error then clean frame
    clear_counts();
    send_byte(8'h55, 1'b0);
    wait_clks(BIT);
    check("t4_fe_pulses", fe_cnt, 1);
    check("t4_no_valid", valid_cycles, 0);
    send_byte(8'h3C, 1'b1);
    wait_clks(20);
    check("t4_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t4_data", rx_q[0], 8'h3C);
    check("t4_fe_after", fe_cnt, 1);

    // 5: overrun
    clear_counts();
    ready = 1'b0;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    wait_clks(20);
    check("t5_valid", valid, 1'b1);
    check("t5_data", data, 8'h12);
    check("t5_overrun", ov_cnt, 1);
    ready = 1'b1;
    wait_clks(1);
    ready = 1'b0;
    wait_clks(1);
    check("t5_valid_fall", valid, 1'b0);
    check("t5_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t5_taken", rx_q[0], 8'h12);
    ready = 1'b1;
    wait_clks(50);

    // 6: reset during bit 4 of 0xA5, line low through reset
    clear_counts();
    drv_line = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      drv_line = (i % 2 == 0);
      wait_clks(BIT);
    end
    drv_line = 1'b0;
    wait_clks(BIT / 2);
    check("t6_busy_before_reset", busy, 1'b1);
    reset = 1'b1;
    wait_clks(10);
    reset = 1'b0;
    wait_clks(20);
    check("t6_busy_after_reset", busy, 1'b0);
    wait_clks(12 * BIT);
    check("t6_busy_low_line", busy, 1'b0);
    check("t6_no_frame", rx_q.size() + fe_cnt + ov_cnt, 0);
    drv_line = 1'b1;
    wait_clks(2 * BIT);
    send_byte(8'hC3, 1'b1);
    wait_clks(20);
    check("t6_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t6_data", rx_q[0], 8'hC3);

    // 7: loopback from the transmitter
    clear_counts();
    use_tx  = 1'b1;
    tx_byte = 8'hAB;
    tx_go   = 1'b1;
    wait_clks(1);
    tx_go   = 1'b0;
    for (int i = 0; i < 20 * BIT && rx_q.size() == 0; i++) wait_clks(1);
    check("t7_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t7_data", rx_q[0], 8'hAB);
    check("t7_flags", fe_cnt + ov_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
